// File: rtl/updown_counter_mod.sv
// rtl/updown_counter_mod.sv - modulo-(MAX_VAL+1) load/up/down counter with step, tc pulse and sticky ovf/unf
// Optional saturate mode (sat port) is built only when COUNTER_SAT_EN is defined.
module updown_counter_mod #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_VAL = (2**WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             updown,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] step,
  input  logic             clr_flags,
`ifdef COUNTER_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  // One extra bit keeps the modulus (up to 2**WIDTH) and the up-count sum representable.
  localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   ONE_W = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   MOD_W = MAX_W + ONE_W;
  localparam logic [WIDTH-1:0] MAX_N = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO_N = '0;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             sat_mode;
  logic [WIDTH:0]   step_mod;
  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   up_sum;
  logic             up_wrap;
  logic             dn_wrap;
  logic [WIDTH-1:0] up_val;
  logic [WIDTH-1:0] dn_val;
  logic [WIDTH-1:0] load_val;
  logic             ovf_evt;
  logic             unf_evt;

`ifdef COUNTER_SAT_EN
  assign sat_mode = sat;
`else
  assign sat_mode = 1'b0;
`endif

  // Oversized steps are folded into range first, so a single step wraps at most once.
  always_comb begin
    step_mod = {1'b0, step} % MOD_W;
    cnt_ext  = {1'b0, cnt_q};
    up_sum   = cnt_ext + step_mod;
    up_wrap  = (up_sum > MAX_W);
    dn_wrap  = (cnt_ext < step_mod);

    if (!up_wrap) begin
      up_val = WIDTH'(up_sum);
    end else if (sat_mode) begin
      up_val = MAX_N;
    end else begin
      up_val = WIDTH'(up_sum - MOD_W);
    end

    if (!dn_wrap) begin
      dn_val = WIDTH'(cnt_ext - step_mod);
    end else if (sat_mode) begin
      dn_val = ZERO_N;
    end else begin
      dn_val = WIDTH'(cnt_ext + (MOD_W - step_mod));
    end

    load_val = ({1'b0, data} > MAX_W) ? MAX_N : data;
  end

  always_comb begin
    cnt_d   = cnt_q;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;

    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      if (updown) begin
        cnt_d   = up_val;
        ovf_evt = up_wrap;
      end else begin
        cnt_d   = dn_val;
        unf_evt = dn_wrap;
      end
    end

    // A fresh event on the same edge as clr_flags leaves the flag set.
    tc_d  = ovf_evt | unf_evt;
    ovf_d = (ovf_q & ~clr_flags) | ovf_evt;
    unf_d = (unf_q & ~clr_flags) | unf_evt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign data_out = cnt_q;
  assign tc       = tc_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// tb/tb_updown_counter_mod.sv - directed and random checks of updown_counter_mod against a modulo-arithmetic model
module tb_updown_counter_mod;

  localparam int W  = 4;
  localparam int MX = 9;
  localparam int M  = MX + 1;

  logic         clk;
  logic         rst;
  logic         load;
  logic         updown;
  logic         en;
  logic [W-1:0] data;
  logic [W-1:0] step;
  logic         clr_flags;
  logic         sat;
  logic [W-1:0] data_out;
  logic         tc;
  logic         ovf;
  logic         unf;

  int checks;
  int errors;

  int m_cnt;
  int m_tc;
  int m_ovf;
  int m_unf;

  updown_counter_mod #(
    .WIDTH(W),
    .MAX_VAL(MX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .updown(updown),
    .en(en),
    .data(data),
    .step(step),
    .clr_flags(clr_flags),
`ifdef COUNTER_SAT_EN
    .sat(sat),
`endif
    .data_out(data_out),
    .tc(tc),
    .ovf(ovf),
    .unf(unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: counting is plain arithmetic on integers mod M.
  task automatic model_edge();
    int s;
    int sum;
    bit sat_on;
    sat_on = 1'b0;
`ifdef COUNTER_SAT_EN
    sat_on = sat;
`endif
    if (!rst) begin
      m_cnt = 0; m_tc = 0; m_ovf = 0; m_unf = 0;
    end else if (load) begin
      m_cnt = (int'(data) > MX) ? MX : int'(data);
      m_tc  = 0;
      if (clr_flags) begin m_ovf = 0; m_unf = 0; end
    end else begin
      m_tc = 0;
      if (clr_flags) begin m_ovf = 0; m_unf = 0; end
      if (en) begin
        s = int'(step) % M;
        if (updown) begin
          sum = m_cnt + s;
          if (sum >= M) begin
            m_cnt = sat_on ? MX : sum - M;
            m_tc = 1; m_ovf = 1;
          end else m_cnt = sum;
        end else begin
          if (m_cnt < s) begin
            m_cnt = sat_on ? 0 : ((m_cnt - s) % M + M) % M;
            m_tc = 1; m_unf = 1;
          end else m_cnt = m_cnt - s;
        end
      end
    end
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, ".data_out"}, int'(data_out), m_cnt);
    check({tag, ".tc"},       int'(tc),       m_tc);
    check({tag, ".ovf"},      int'(ovf),      m_ovf);
    check({tag, ".unf"},      int'(unf),      m_unf);
  endtask

  task automatic set_in(input bit r, input bit l, input bit e, input bit ud,
                        input int d, input int st, input bit c);
    rst = r; load = l; en = e; updown = ud;
    data = W'(d); step = W'(st); clr_flags = c;
  endtask

  initial begin
    checks = 0; errors = 0;
    m_cnt = 0; m_tc = 0; m_ovf = 0; m_unf = 0;
    sat = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    cycle("reset");

    set_in(1, 1, 0, 0, 12, 0, 0); cycle("load_clamp");
    check("load_clamp.abs", int'(data_out), 9);

    set_in(1, 1, 0, 0, 8, 0, 0);  cycle("load8");
    set_in(1, 0, 1, 1, 0, 3, 0);  cycle("up_wrap");
    check("up_wrap.abs", int'(data_out), 1);
    set_in(1, 0, 1, 1, 0, 1, 0);  cycle("up_after");

    set_in(1, 1, 0, 0, 1, 0, 0);  cycle("load1");
    set_in(1, 0, 1, 0, 0, 4, 0);  cycle("dn_wrap");
    check("dn_wrap.abs", int'(data_out), 7);
    set_in(1, 0, 1, 0, 0, 9, 1);  cycle("clr_vs_set");
    set_in(1, 0, 0, 0, 0, 0, 1);  cycle("clr_only");
    check("clr_only.unf_abs", int'(unf), 0);

    set_in(1, 1, 1, 1, 5, 2, 0);  cycle("load_over_en");
    set_in(1, 0, 0, 1, 0, 2, 0);
    for (int i = 0; i < 3; i++) cycle("hold");
    check("hold.abs", int'(data_out), 5);

    set_in(1, 0, 1, 1, 0, 1, 0);  cycle("count6");
    set_in(0, 0, 1, 1, 0, 1, 0);  cycle("mid_reset");
    set_in(1, 0, 1, 1, 0, 1, 0);  cycle("post_reset");
    check("post_reset.abs", int'(data_out), 1);

    set_in(1, 0, 1, 1, 0, 0, 0);  cycle("step0");
    set_in(1, 0, 1, 1, 0, 15, 0); cycle("step_big_up");
    set_in(1, 0, 1, 0, 0, 13, 0); cycle("step_big_dn");

`ifdef COUNTER_SAT_EN
    sat = 1'b1;
    set_in(1, 1, 0, 0, 8, 0, 1);  cycle("sat_load8");
    set_in(1, 0, 1, 1, 0, 3, 0);  cycle("sat_up");
    check("sat_up.abs", int'(data_out), 9);
    cycle("sat_up_again");
    set_in(1, 1, 0, 0, 2, 0, 0);  cycle("sat_load2");
    set_in(1, 0, 1, 0, 0, 5, 0);  cycle("sat_dn");
    check("sat_dn.abs", int'(data_out), 0);
`endif

    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
             $urandom_range(0, 15), $urandom_range(0, 15),
             ($urandom_range(0, 7) == 0));
`ifdef COUNTER_SAT_EN
      sat = $urandom_range(0, 1);
`endif
      cycle("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
